// File: rtl/ov_video_axis_bridge.sv
// Sensor vs/hs/de video to AXI4-Stream bridge (tuser=SOF, tlast=EOL).
// One-pixel hold stage for EOL look-ahead, FWFT FIFO for back-pressure.
module ov_video_axis_bridge #(
  parameter int DATA_W     = 24,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK_i,
  input  logic              rst_i,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] rgb_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              overflow_o,
  output logic              line_err_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] H16 = 16'(H_ACTIVE);
  localparam logic [15:0] V16 = 16'(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS,
    ARMED,
    ACTIVE
  } state_t;

  state_t              state_q;
  logic                vs_q;
  logic                hold_vld_q;
  logic                hold_sof_q;
  logic [DATA_W-1:0]   hold_data_q;
  logic [DATA_W+1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q;
  logic [AW-1:0]       rd_q;
  logic [AW:0]         cnt_q;
  logic [AW:0]         cnt_d;
  logic [15:0]         col_q;
  logic [15:0]         line_q;
  logic [15:0]         line_d;
  logic                ovf_q;
  logic                lerr_q;
  logic [15:0]         fcnt_q;

  logic vs_rise;
  logic pop;
  logic push_last;
  logic can_push;
  logic push;
  logic refuse;
  logic capture;
  logic [DATA_W+1:0] head;

  // hsync carries no information here; lines are framed by de_i
  logic unused_hs;
  assign unused_hs = hs_i;

  assign vs_rise   = vs_i & ~vs_q;
  assign m_axis_tvalid = (cnt_q != '0);
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign push_last = ~de_i | vs_rise;
  assign can_push  = (cnt_q < DEPTH) | pop;
  assign push      = hold_vld_q & can_push;
  assign refuse    = hold_vld_q & ~can_push;
  assign capture   = de_i & ~vs_rise & ~refuse &
                     ((state_q == ARMED) | (state_q == ACTIVE));

  assign head         = mem_q[rd_q];
  assign m_axis_tdata = m_axis_tvalid ? head[DATA_W-1:0] : '0;
  assign m_axis_tlast = m_axis_tvalid & head[DATA_W];
  assign m_axis_tuser = m_axis_tvalid & head[DATA_W+1];

  assign overflow_o  = ovf_q;
  assign line_err_o  = lerr_q;
  assign frame_cnt_o = fcnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop) cnt_d = cnt_q + 1'b1;
    if (~push & pop) cnt_d = cnt_q - 1'b1;
    line_d = line_q + {15'd0, push & push_last};
  end

  always_ff @(posedge CLK_i) begin
    if (push) mem_q[wr_q] <= {hold_sof_q, push_last, hold_data_q};
  end

  always_ff @(posedge CLK_i) begin
    if (rst_i) begin
      state_q     <= WAIT_VS;
      vs_q        <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_sof_q  <= 1'b0;
      hold_data_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      col_q       <= '0;
      line_q      <= '0;
      ovf_q       <= 1'b0;
      lerr_q      <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      vs_q  <= vs_i;
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;

      if (push) begin
        if (push_last) begin
          col_q  <= '0;
          line_q <= line_d;
          if (col_q + 16'd1 != H16) lerr_q <= 1'b1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end

      hold_vld_q <= capture;
      if (capture) begin
        hold_data_q <= rgb_i;
        hold_sof_q  <= (state_q == ARMED);
      end

      if (refuse) ovf_q <= 1'b1;

      unique case (state_q)
        WAIT_VS: if (vs_rise) state_q <= ARMED;
        ARMED:   if (capture) state_q <= ACTIVE;
        ACTIVE: begin
          if (refuse) begin
            state_q <= WAIT_VS;
          end else if (vs_rise) begin
            state_q <= ARMED;
            fcnt_q  <= fcnt_q + 16'd1;
            if (line_d != V16) lerr_q <= 1'b1;
          end
        end
        default: state_q <= WAIT_VS;
      endcase

      // frame boundary (or drop) restarts line bookkeeping
      if (vs_rise | refuse) begin
        col_q  <= '0;
        line_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ov_video_axis_bridge.sv
// Directed bench for ov_video_axis_bridge (V_ACTIVE reduced to 8 to
// keep full-frame runs short; H_ACTIVE stays 640).
module tb_ov_video_axis_bridge;

  localparam int H = 640;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0;
  logic        hs = 1'b0;
  logic        de = 1'b0;
  logic [23:0] rgb = '0;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tuser;
  logic        tlast;
  logic        ovf;
  logic        lerr;
  logic [15:0] fcnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int de_cyc = 0;
  int base = 0;
  logic prev_vld = 1'b0;
  logic [25:0] q[$];

  ov_video_axis_bridge #(
    .DATA_W(24), .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16)
  ) dut (
    .CLK_i(clk), .rst_i(rst), .vs_i(vs), .hs_i(hs), .de_i(de),
    .rgb_i(rgb), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .overflow_o(ovf), .line_err_o(lerr),
    .frame_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && !prev_vld) rise_cyc = cyc;
    prev_vld = tvalid;
    if (tvalid && tready && !rst) q.push_back({tuser, tlast, tdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    de = 1'b0;
    vs = 1'b0;
    tready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_line(input int n, input int ln, input int stall_at);
    for (int c = 0; c < n; c++) begin
      if (c == 0) de_cyc = cyc;
      if (c == stall_at) begin
        tready = 1'b0;
        base = q.size();
      end
      if (stall_at >= 0 && c == stall_at + 40) tready = 1'b1;
      de = 1'b1;
      rgb = {12'(ln), 12'(c)};
      tick();
    end
    de = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tvalid && n < 300) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 300), 32'd1);
  endtask

  function automatic int nb();
    return q.size() - base;
  endfunction

  initial begin
    int bu, bl, bd, idx;
    logic [25:0] b;

    // 1: four 640-pixel lines
    do_reset();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_flags", {29'd0, ovf, lerr, tuser}, 32'd0);
    chk("rst_fcnt", 32'(fcnt), 32'd0);
    vs_pulse();
    base = q.size();
    for (int l = 0; l < 4; l++) send_line(H, l, -1);
    wait_idle();
    chk("t1_latency", 32'(rise_cyc - de_cyc), 32'd2);
    chk("t1_beats", 32'(nb()), 32'd2560);
    bu = 0; bl = 0; bd = 0;
    for (int i = 0; i < nb() && i < 2560; i++) begin
      b = q[base + i];
      if (b[25] !== (i == 0)) bu++;
      if (b[24] !== ((i % H) == H - 1)) bl++;
      if (b[23:0] !== {12'(i / H), 12'(i % H)}) bd++;
    end
    chk("t1_tuser", 32'(bu), 32'd0);
    chk("t1_tlast", 32'(bl), 32'd0);
    chk("t1_data", 32'(bd), 32'd0);
    chk("t1_ovf_lerr", {30'd0, ovf, lerr}, 32'd0);

    // 2: pixels before any vsync are discarded
    do_reset();
    base = q.size();
    send_line(H, 0, -1);
    send_line(H, 1, -1);
    chk("t2_beats", 32'(nb()), 32'd0);
    chk("t2_ovf", 32'(ovf), 32'd0);

    // 3: 40-cycle stall mid-line overflows the 16-entry FIFO
    do_reset();
    vs_pulse();
    send_line(H, 0, 100);
    send_line(H, 1, -1);
    wait_idle();
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_drain", 32'(nb()), 32'd16);
    bl = 0; bd = 0;
    for (int i = 0; i < nb() && i < 16; i++) begin
      b = q[base + i];
      if (b[24] !== 1'b0) bl++;
      if (b[11:0] !== q[base][11:0] + 12'(i)) bd++;
    end
    chk("t3_no_tlast", 32'(bl), 32'd0);
    chk("t3_contig", 32'(bd), 32'd0);
    vs_pulse();
    chk("t3_fcnt", 32'(fcnt), 32'd0);
    base = q.size();
    send_line(H, 0, -1);
    wait_idle();
    chk("t3_next_beats", 32'(nb()), 32'(H));
    idx = (nb() > 0) ? base : 0;
    b = q[idx];
    chk("t3_next_sof", {30'd0, b[25:24]}, 32'd2);
    b = q[base + H - 1];
    chk("t3_next_eol", 32'(b[24]), 32'd1);

    // 4: short line of 639 pixels
    do_reset();
    vs_pulse();
    base = q.size();
    send_line(H - 1, 0, -1);
    wait_idle();
    chk("t4_beats", 32'(nb()), 32'(H - 1));
    b = q[base + H - 2];
    chk("t4_eol", {7'd0, b}, {8'd0, 2'b01, 12'd0, 12'(H - 2)});
    chk("t4_lerr", 32'(lerr), 32'd1);

    // 5: full frame, then vsync closes it
    do_reset();
    vs_pulse();
    base = q.size();
    for (int l = 0; l < V; l++) send_line(H, l, -1);
    wait_idle();
    chk("t5_beats", 32'(nb()), 32'(H * V));
    chk("t5_fcnt_pre", 32'(fcnt), 32'd0);
    vs_pulse();
    chk("t5_fcnt", 32'(fcnt), 32'd1);
    chk("t5_lerr", 32'(lerr), 32'd0);

    // 6: reset mid-line with FIFO partly filled
    tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      de = 1'b1;
      rgb = 24'(c);
      tick();
    end
    chk("t6_pre_vld", 32'(tvalid), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_tvalid", 32'(tvalid), 32'd0);
    chk("t6_outs", {5'd0, tuser, tlast, ovf, lerr, tdata}, 32'd0);
    chk("t6_fcnt", 32'(fcnt), 32'd0);
    rst = 1'b0;
    tready = 1'b1;
    base = q.size();
    send_line(100, 0, -1);
    chk("t6_wait_vs", 32'(nb()), 32'd0);
    vs_pulse();
    send_line(H, 0, -1);
    wait_idle();
    chk("t6_resync", 32'(nb()), 32'(H));
    idx = (nb() > 0) ? base : 0;
    b = q[idx];
    chk("t6_sof", 32'(b[25]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
